dccm_banked: RTL and testbench

DCCM_BANKED -- requirements
Module: dccm_banked

---
 rtl/dccm_banked.sv | 244 ++++++++++++++++++++++++
 tb/tb_dccm_banked.sv | 255 +++++++++++++++++++++++++
 2 files changed

// File: rtl/dccm_banked.sv
// -----------------------------------------------------------------------------
// dccm_banked
//
// Word-interleaved, banked data memory with one read port and one write port.
// The low address bits select the bank, the remaining bits select the row
// inside that bank. Because banks are interleaved on the low bits, the
// physical storage is kept as one flat array indexed by the full word address
// ({row, bank}). Bank identity is used only to detect read/write conflicts.
//
// Reads are always accepted, one per cycle, and return after RD_LATENCY cycles
// together with their tag. A write that targets the same bank as a same-cycle
// read loses to the read and is parked in a one-entry write buffer. The buffer
// drains in the first cycle in which no read targets its bank. While the
// buffer is occupied, wready is low and new writes are not accepted. Reads
// that hit the buffered address see the buffered bytes merged over memory.
//
// Ports
//   clk          : single clock
//   rstn         : asynchronous active-low reset (memory contents retained)
//   raddr        : read word address
//   rvalid_in    : read request
//   rtag_in      : tag returned with the read data
//   rdata        : read data (valid when rvalid_out)
//   rtag_out     : tag of the returned read
//   rvalid_out   : rdata / rtag_out valid
//   waddr        : write word address
//   wen          : write request (accepted only when wready is high)
//   wbe          : write byte enables
//   wdata        : write data
//   wready       : write accepted this cycle (registered, low while buffered)
//   conflict_cnt : saturating count of read/write bank conflicts
// -----------------------------------------------------------------------------
module dccm_banked #(
  parameter int    DEPTH      = 16384,
  parameter int    WIDTH      = 32,
  parameter int    NUM_BANKS  = 4,
  parameter int    RD_LATENCY = 1,
  parameter int    TAG_WIDTH  = 4,
  parameter string INIT_FILE  = ""
) (
  input  logic                     clk,
  input  logic                     rstn,
  input  logic [$clog2(DEPTH)-1:0] raddr,
  input  logic                     rvalid_in,
  input  logic [TAG_WIDTH-1:0]     rtag_in,
  output logic [WIDTH-1:0]         rdata,
  output logic [TAG_WIDTH-1:0]     rtag_out,
  output logic                     rvalid_out,
  input  logic [$clog2(DEPTH)-1:0] waddr,
  input  logic                     wen,
  input  logic [WIDTH/8-1:0]       wbe,
  input  logic [WIDTH-1:0]         wdata,
  output logic                     wready,
  output logic [31:0]              conflict_cnt
);

  localparam int AW     = $clog2(DEPTH);
  localparam int NBYTES = WIDTH / 8;

  // Bank bits are the low log2(NUM_BANKS) address bits. With a single bank
  // the mask is zero, so every read/write pair compares as the same bank.
  localparam logic [AW-1:0] BANK_MASK = AW'(NUM_BANKS - 1);

  // ---------------------------------------------------------------------------
  // Helpers
  // ---------------------------------------------------------------------------

  // True when two word addresses map to the same bank.
  function automatic logic same_bank(input logic [AW-1:0] a,
                                     input logic [AW-1:0] b);
    return (((a ^ b) & BANK_MASK) == {AW{1'b0}});
  endfunction

  // Replace the bytes of old_w selected by be with the bytes of new_w.
  function automatic logic [WIDTH-1:0] merge_bytes(input logic [WIDTH-1:0]  old_w,
                                                   input logic [WIDTH-1:0]  new_w,
                                                   input logic [NBYTES-1:0] be);
    logic [WIDTH-1:0] res;
    res = old_w;
    for (int i = 0; i < NBYTES; i++) begin
      if (be[i]) begin
        res[8*i +: 8] = new_w[8*i +: 8];
      end else begin
        res[8*i +: 8] = old_w[8*i +: 8];
      end
    end
    return res;
  endfunction

  // ---------------------------------------------------------------------------
  // Storage
  // ---------------------------------------------------------------------------
  logic [WIDTH-1:0] mem [DEPTH];

  // ---------------------------------------------------------------------------
  // State
  // ---------------------------------------------------------------------------
  logic                  wbuf_valid_q, wbuf_valid_d;
  logic [AW-1:0]         wbuf_addr_q,  wbuf_addr_d;
  logic [NBYTES-1:0]     wbuf_be_q,    wbuf_be_d;
  logic [WIDTH-1:0]      wbuf_data_q,  wbuf_data_d;
  logic                  wready_q,     wready_d;
  logic [31:0]           conflict_cnt_q, conflict_cnt_d;

  logic                  rd_valid_q [RD_LATENCY];
  logic [WIDTH-1:0]      rd_data_q  [RD_LATENCY];
  logic [TAG_WIDTH-1:0]  rd_tag_q   [RD_LATENCY];

  // Combinational control
  logic                  wr_acc_s;
  logic                  conflict_s;
  logic                  drain_s;
  logic                  mem_we_s;
  logic [AW-1:0]         mem_waddr_s;
  logic [NBYTES-1:0]     mem_wbe_s;
  logic [WIDTH-1:0]      mem_wdata_s;
  logic [WIDTH-1:0]      rd_word_s;

  // ---------------------------------------------------------------------------
  // Write arbitration, write buffer and conflict counter next state
  // ---------------------------------------------------------------------------

  // Decide this cycle's memory write (direct or drain) and next buffer state.
  always_comb begin
    wr_acc_s   = wen & wready_q;
    conflict_s = wr_acc_s & rvalid_in & same_bank(raddr, waddr);
    // The buffer may drain only while no read touches its bank. Since wready
    // mirrors an empty buffer, a drain and a new accepted write never coincide.
    drain_s    = wbuf_valid_q & ~(rvalid_in & same_bank(raddr, wbuf_addr_q));

    mem_we_s    = 1'b0;
    mem_waddr_s = waddr;
    mem_wbe_s   = wbe;
    mem_wdata_s = wdata;
    if (wr_acc_s && !conflict_s) begin
      mem_we_s    = 1'b1;
      mem_waddr_s = waddr;
      mem_wbe_s   = wbe;
      mem_wdata_s = wdata;
    end else if (drain_s) begin
      mem_we_s    = 1'b1;
      mem_waddr_s = wbuf_addr_q;
      mem_wbe_s   = wbuf_be_q;
      mem_wdata_s = wbuf_data_q;
    end else begin
      mem_we_s    = 1'b0;
    end

    wbuf_valid_d = wbuf_valid_q;
    wbuf_addr_d  = wbuf_addr_q;
    wbuf_be_d    = wbuf_be_q;
    wbuf_data_d  = wbuf_data_q;
    if (conflict_s) begin
      wbuf_valid_d = 1'b1;
      wbuf_addr_d  = waddr;
      wbuf_be_d    = wbe;
      wbuf_data_d  = wdata;
    end else if (drain_s) begin
      wbuf_valid_d = 1'b0;
    end else begin
      wbuf_valid_d = wbuf_valid_q;
    end

    wready_d = ~wbuf_valid_d;

    if (conflict_s && (conflict_cnt_q != 32'hFFFF_FFFF)) begin
      conflict_cnt_d = conflict_cnt_q + 32'd1;
    end else begin
      conflict_cnt_d = conflict_cnt_q;
    end
  end

  // Register the write buffer, wready and conflict counter.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      wbuf_valid_q   <= 1'b0;
      wbuf_addr_q    <= {AW{1'b0}};
      wbuf_be_q      <= {NBYTES{1'b0}};
      wbuf_data_q    <= {WIDTH{1'b0}};
      wready_q       <= 1'b1;
      conflict_cnt_q <= 32'd0;
    end else begin
      wbuf_valid_q   <= wbuf_valid_d;
      wbuf_addr_q    <= wbuf_addr_d;
      wbuf_be_q      <= wbuf_be_d;
      wbuf_data_q    <= wbuf_data_d;
      wready_q       <= wready_d;
      conflict_cnt_q <= conflict_cnt_d;
    end
  end

  // Memory write port; contents are deliberately not reset.
  always_ff @(posedge clk) begin
    if (mem_we_s) begin
      mem[mem_waddr_s] <= merge_bytes(mem[mem_waddr_s], mem_wdata_s, mem_wbe_s);
    end
  end

  // ---------------------------------------------------------------------------
  // Read path
  // ---------------------------------------------------------------------------

  // Read word as seen by this cycle's read: memory before any same-cycle
  // write, overlaid with buffered bytes when the buffer holds this address.
  always_comb begin
    rd_word_s = mem[raddr];
    if (wbuf_valid_q && (wbuf_addr_q == raddr)) begin
      rd_word_s = merge_bytes(mem[raddr], wbuf_data_q, wbuf_be_q);
    end else begin
      rd_word_s = mem[raddr];
    end
  end

  // Read return pipeline of RD_LATENCY stages; the last stage drives outputs.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      for (int i = 0; i < RD_LATENCY; i++) begin
        rd_valid_q[i] <= 1'b0;
        rd_data_q[i]  <= {WIDTH{1'b0}};
        rd_tag_q[i]   <= {TAG_WIDTH{1'b0}};
      end
    end else begin
      rd_valid_q[0] <= rvalid_in;
      if (rvalid_in) begin
        rd_data_q[0] <= rd_word_s;
        rd_tag_q[0]  <= rtag_in;
      end
      for (int i = 1; i < RD_LATENCY; i++) begin
        rd_valid_q[i] <= rd_valid_q[i-1];
        if (rd_valid_q[i-1]) begin
          rd_data_q[i] <= rd_data_q[i-1];
          rd_tag_q[i]  <= rd_tag_q[i-1];
        end
      end
    end
  end

  assign rvalid_out   = rd_valid_q[RD_LATENCY-1];
  assign rdata        = rd_data_q[RD_LATENCY-1];
  assign rtag_out     = rd_tag_q[RD_LATENCY-1];
  assign wready       = wready_q;
  assign conflict_cnt = conflict_cnt_q;

endmodule

// File: tb/tb_dccm_banked.sv
// -----------------------------------------------------------------------------
// tb_dccm_banked
//
// Bench for dccm_banked (DEPTH=64, 4 banks, RD_LATENCY=2). A transaction-level
// model (flat word array, one pending buffered write, queue of returning reads)
// is compared against the DUT every cycle; directed sequences add literal
// expectations at the key points.
// -----------------------------------------------------------------------------
module tb_dccm_banked;

  localparam int DEPTH = 64;
  localparam int WIDTH = 32;
  localparam int NB    = 4;
  localparam int LAT   = 2;
  localparam int TW    = 4;

  logic        clk = 1'b0;
  logic        rstn = 1'b0;
  logic [5:0]  raddr = 6'd0;
  logic        rvalid_in = 1'b0;
  logic [3:0]  rtag_in = 4'd0;
  logic [31:0] rdata;
  logic [3:0]  rtag_out;
  logic        rvalid_out;
  logic [5:0]  waddr = 6'd0;
  logic        wen = 1'b0;
  logic [3:0]  wbe = 4'd0;
  logic [31:0] wdata = 32'd0;
  logic        wready;
  logic [31:0] conflict_cnt;

  always #5 clk = ~clk;

  dccm_banked #(
    .DEPTH(DEPTH), .WIDTH(WIDTH), .NUM_BANKS(NB),
    .RD_LATENCY(LAT), .TAG_WIDTH(TW), .INIT_FILE("")
  ) dut (
    .clk(clk), .rstn(rstn),
    .raddr(raddr), .rvalid_in(rvalid_in), .rtag_in(rtag_in),
    .rdata(rdata), .rtag_out(rtag_out), .rvalid_out(rvalid_out),
    .waddr(waddr), .wen(wen), .wbe(wbe), .wdata(wdata),
    .wready(wready), .conflict_cnt(conflict_cnt)
  );

  int errors = 0;
  int checks = 0;
  logic chk_en = 1'b0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- model ----------------
  typedef struct {
    int          due;
    logic [31:0] data;
    logic [3:0]  tag;
  } rd_t;

  rd_t         rq[$];
  logic [31:0] m_mem [DEPTH];
  logic        m_bv = 1'b0;
  logic [5:0]  m_ba = 6'd0;
  logic [3:0]  m_bbe = 4'd0;
  logic [31:0] m_bd = 32'd0;
  logic [31:0] m_cnt = 32'd0;
  logic        m_wready = 1'b1;
  int          cyc = 0;

  function automatic logic [31:0] apply_be(input logic [31:0] old_w, input logic [31:0] new_w,
                                           input logic [3:0] be);
    logic [31:0] r;
    r = old_w;
    for (int b = 0; b < 4; b++) if (be[b]) r[8*b +: 8] = new_w[8*b +: 8];
    return r;
  endfunction

  // Model: update at each clock edge from the inputs held during the cycle.
  always @(posedge clk or negedge rstn) begin
    cyc = cyc + 1;
    if (!rstn) begin
      rq.delete();
      m_bv = 1'b0;
      m_cnt = 32'd0;
      m_wready = 1'b1;
    end else begin
      if (rvalid_in) begin
        rd_t r;
        r.data = m_mem[raddr];
        if (m_bv && m_ba == raddr) r.data = apply_be(r.data, m_bd, m_bbe);
        r.tag = rtag_in;
        r.due = cyc - 1 + LAT;
        rq.push_back(r);
      end
      if (wen && m_wready) begin
        if (rvalid_in && (int'(raddr) % NB) == (int'(waddr) % NB)) begin
          m_bv = 1'b1; m_ba = waddr; m_bbe = wbe; m_bd = wdata;
          if (m_cnt != 32'hFFFF_FFFF) m_cnt = m_cnt + 32'd1;
        end else begin
          m_mem[waddr] = apply_be(m_mem[waddr], wdata, wbe);
        end
      end else if (m_bv && !(rvalid_in && (int'(raddr) % NB) == (int'(m_ba) % NB))) begin
        m_mem[m_ba] = apply_be(m_mem[m_ba], m_bd, m_bbe);
        m_bv = 1'b0;
      end
      m_wready = !m_bv;
    end
  end

  // Compare: every cycle, away from the active edge.
  always @(negedge clk) begin
    if (chk_en) begin
      logic exp_v;
      exp_v = (rq.size() > 0) && (rq[0].due == cyc);
      check("rvalid_out", {31'd0, rvalid_out}, {31'd0, exp_v});
      if (exp_v) begin
        check("rdata", rdata, rq[0].data);
        check("rtag_out", {28'd0, rtag_out}, {28'd0, rq[0].tag});
        void'(rq.pop_front());
      end
      check("wready", {31'd0, wready}, {31'd0, m_wready});
      check("conflict_cnt", conflict_cnt, m_cnt);
    end
  end

  // ---------------- stimulus ----------------
  task automatic drive(input logic rv, input logic [5:0] ra, input logic [3:0] rt,
                       input logic we, input logic [5:0] wa, input logic [3:0] be,
                       input logic [31:0] wd);
    rvalid_in = rv; raddr = ra; rtag_in = rt;
    wen = we; waddr = wa; wbe = be; wdata = wd;
    @(negedge clk);
  endtask

  task automatic idle();
    drive(1'b0, 6'd0, 4'd0, 1'b0, 6'd0, 4'd0, 32'd0);
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    repeat (2) @(negedge clk);
    chk_en = 1'b1;
    check("reset rvalid_out", {31'd0, rvalid_out}, 32'd0);
    check("reset wready", {31'd0, wready}, 32'd1);
    check("reset conflict_cnt", conflict_cnt, 32'd0);
    #2 rstn = 1'b1;
    @(negedge clk);

    // Known contents for the addresses used below.
    for (int a = 0; a < 16; a++) drive(1'b0, 6'd0, 4'd0, 1'b1, 6'(a), 4'hF, 32'd0);

    // Write then read with latency 2.
    drive(1'b0, 6'd0, 4'd0, 1'b1, 6'd5, 4'hF, 32'hDEAD_BEEF);
    drive(1'b1, 6'd5, 4'd3, 1'b0, 6'd0, 4'd0, 32'd0);
    check("lat1 rvalid", {31'd0, rvalid_out}, 32'd0);
    idle();
    check("lat2 rvalid", {31'd0, rvalid_out}, 32'd1);
    check("lat2 rdata", rdata, 32'hDEAD_BEEF);
    check("lat2 rtag", {28'd0, rtag_out}, 32'd3);

    // Bank conflict: read 4, write 8 (both bank 0).
    drive(1'b1, 6'd4, 4'd1, 1'b1, 6'd8, 4'hF, 32'h1122_3344);
    check("conflict cnt", conflict_cnt, 32'd1);
    check("conflict wready", {31'd0, wready}, 32'd0);
    idle();
    check("drained wready", {31'd0, wready}, 32'd1);
    drive(1'b1, 6'd8, 4'd2, 1'b0, 6'd0, 4'd0, 32'd0);
    idle();
    idle();
    check("addr8 rdata", rdata, 32'h1122_3344);

    // Partial buffered write, read while buffered; ignored write to 3.
    drive(1'b1, 6'd0, 4'd4, 1'b1, 6'd8, 4'b0011, 32'hAABB_CCDD);
    drive(1'b1, 6'd8, 4'd5, 1'b1, 6'd3, 4'hF, 32'hFFFF_FFFF);
    idle();
    check("merge rdata", rdata, 32'h1122_CCDD);
    check("merge rtag", {28'd0, rtag_out}, 32'd5);
    drive(1'b1, 6'd3, 4'd6, 1'b0, 6'd0, 4'd0, 32'd0);
    idle();
    idle();
    check("ignored write", rdata, 32'd0);

    // Same address read+write: read-before-write, then new value.
    drive(1'b1, 6'd12, 4'd7, 1'b1, 6'd12, 4'hF, 32'h0000_0005);
    drive(1'b1, 6'd12, 4'd8, 1'b0, 6'd0, 4'd0, 32'd0);
    check("rbw old", rdata, 32'd0);
    idle();
    check("rbw new", rdata, 32'h0000_0005);

    // Different banks in the same cycle: direct write, no conflict.
    drive(1'b1, 6'd1, 4'd9, 1'b1, 6'd2, 4'b1010, 32'hCAFE_F00D);
    check("nobank wready", {31'd0, wready}, 32'd1);
    check("nobank cnt", conflict_cnt, 32'd3);
    drive(1'b1, 6'd2, 4'd10, 1'b0, 6'd0, 4'd0, 32'd0);
    idle();
    check("byte wr rdata", rdata, 32'hCA00_F000);
    idle();

    // Reset with reads in flight and the buffer full.
    drive(1'b1, 6'd0, 4'd11, 1'b0, 6'd0, 4'd0, 32'd0);
    drive(1'b1, 6'd1, 4'd12, 1'b1, 6'd9, 4'hF, 32'h9999_9999);
    drive(1'b1, 6'd13, 4'd13, 1'b0, 6'd0, 4'd0, 32'd0);
    #2;
    rstn = 1'b0;
    rvalid_in = 1'b0; wen = 1'b0;
    #1;
    check("async rvalid", {31'd0, rvalid_out}, 32'd0);
    check("async wready", {31'd0, wready}, 32'd1);
    check("async cnt", conflict_cnt, 32'd0);
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      check("in reset rvalid", {31'd0, rvalid_out}, 32'd0);
    end
    #2 rstn = 1'b1;
    @(negedge clk);
    drive(1'b1, 6'd9, 4'd14, 1'b0, 6'd0, 4'd0, 32'd0);
    idle();
    idle();
    check("discarded wbuf", rdata, 32'd0);
    check("post reset cnt", conflict_cnt, 32'd0);

    // Mixed traffic over the initialised region.
    for (int k = 0; k < 80; k++) begin
      drive(1'($urandom_range(0, 1)), 6'($urandom_range(0, 15)), 4'($urandom_range(0, 15)),
            1'($urandom_range(0, 1)), 6'($urandom_range(0, 15)), 4'($urandom_range(0, 15)),
            $urandom());
    end
    repeat (4) idle();

    // Saturation of the conflict counter.
    force dut.conflict_cnt_q = 32'hFFFF_FFFD;
    m_cnt = 32'hFFFF_FFFD;
    idle();
    release dut.conflict_cnt_q;
    for (int k = 0; k < 4; k++) begin
      drive(1'b1, 6'd0, 4'd0, 1'b1, 6'd4, 4'hF, 32'(k));
      idle();
    end
    check("saturated cnt", conflict_cnt, 32'hFFFF_FFFF);
    repeat (4) idle();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
